sparse_round_scheduler: RTL
===========================

// Module: sparse_round_scheduler
// PURPOSE
//  Upstream sequencer for the sparse-by-dense polymult controller. Walks the sparse-position memory,
//  range-checks each packed {high,low} position pair and presents it to the controller. Runs one
//  controller round per pair using a start pulse and a busy-edge handshake, then reports overall done.
//  With DUMMY_INSERT_EN, pads every job to a fixed round count so run time does not depend on weight.
// PARAMETERS
//  WORD_WIDTH       32     sparse word width; [31:16]=high position, [15:0]=low position
//  MEM_SPARSE_SIZE  50     max sparse entries per job; also the padded round count
//  POLY_BITS        17669  polynomial length n; a valid position is < POLY_BITS
//  ADDR_W           10     sparse memory address width
// PORTS
//  clk              in   1   single clock, rising edge
//  rst              in   1   synchronous, active-high reset
//  start            in   1   job start pulse; ignored while busy
//  sparse_count     in   6   number of valid entries (sampled at start; 0..MEM_SPARSE_SIZE)
//  sparse_mem_addr_o out ADDR_W  sparse memory read address
//  sparse_mem_data_i in  32  sparse memory read data (1-cycle synchronous read)
//  ctrl_word_o      out  32  position pair to controller; stable from ctrl_start_o until round end
//  ctrl_start_o     out  1   one-cycle round start pulse to controller
//  ctrl_dummy_o     out  1   current round is a dummy; downstream gates its acc writes
//  ctrl_busy_i      in   1   controller busy
//  round_idx_o      out  6   index of current/last issued round
//  busy             out  1   job in progress
//  done             out  1   one-cycle pulse at job end
//  range_err        out  1   sticky; a position >= POLY_BITS was seen; cleared at start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; LFSR = 16'hACE1.
//  FSM: IDLE -> FETCH -> LATCH -> ISSUE -> WAIT_ACK -> WAIT_END -> (FETCH | FINISH) -> IDLE.
//   IDLE: on start, latch count (clamped to MEM_SPARSE_SIZE), rd_ptr=0, round=0, busy=1,
//         range_err=0. If count==0 and DUMMY_INSERT_EN is not defined, go to FINISH.
//   FETCH: drive sparse_mem_addr_o=rd_ptr. LATCH: capture sparse_mem_data_i.
//   Range check: if either half >= POLY_BITS, set range_err, skip the entry (rd_ptr++,
//     round unchanged), and return to FETCH.
//   ISSUE: drive ctrl_word_o, pulse ctrl_start_o for exactly 1 cycle.
//   WAIT_ACK: wait for ctrl_busy_i==1. WAIT_END: wait for ctrl_busy_i==0 (falling edge ends
//     the round). The controller's process_done is sticky and is NOT used.
//   After a round end: round++. Next fetch if rd_ptr<count; otherwise FINISH.
//   FINISH: done=1 for 1 cycle, busy=0, return to IDLE. round_idx_o holds its last value.
//  Timing: latency from start to first ctrl_start_o is 3 cycles. Inter-round gap after busy
//   falls is 3 cycles.
//  ctrl_word_o changes only in LATCH, so it is stable for the controller's READ_SPARSE sample.
//  start while busy: ignored. Reset mid-job: immediate return to IDLE; no done pulse; all
//   outputs go to their reset values.
//  Arithmetic: rd_ptr and round are 6-bit, with no wrap because the bound is <= MEM_SPARSE_SIZE.
//   Comparisons are unsigned 16-bit.
// CONFIGURATION
//  `DUMMY_INSERT_EN defined:
//   - After the real entries, issue dummy rounds until round==MEM_SPARSE_SIZE.
//   - Dummy word = {lfsr_a mod POLY_BITS, lfsr_b mod POLY_BITS}, from two successive 16-bit
//     Galois LFSR steps (taps 0xB400). Modulo is by conditional subtract, so it is always in range.
//   - ctrl_dummy_o=1 from ISSUE to round end. Out-of-range skips are also back-filled by dummies.
//  Not defined: exactly the accepted real rounds are issued. ctrl_dummy_o is tied 0 and there
//   is no LFSR logic.
// STRUCTURE
//  Package polymult_pkg: state enum, POLY_BITS, MEM_SPARSE_SIZE, pos_hi/pos_lo field slices,
//   LFSR seed and taps.
//  Sub-module (only under DUMMY_INSERT_EN): dummy_pos_gen. It contains the LFSR and the modular
//   reduction, and returns a valid 32-bit pair on a next-request pulse with 1-cycle latency.
// TESTING
//  1. count=3, entries {0x0005_0100, 0x1000_2000, 0x44E4_0000}, model busy 10 cycles ->
//     3 start pulses with matching words, done after the 3rd busy fall, range_err=0.
//  2. count=2, entry0=0x4505_0001 (0x4505=17669) -> range_err=1, only 1 round issued.
//     With the EN macro: 50 rounds issued, 49 with dummy=1.
//  3. count=0 -> no EN: done 2 cycles after start with 0 rounds. EN: 50 dummy rounds, all
//     positions < 17669.
//  4. start re-pulsed during round 1 of 3 -> ignored, and the sequence is unchanged.
//  5. rst asserted in WAIT_END of round 2 -> next cycle all outputs 0; a new start runs
//     normally from entry 0.
//  6. Controller holds busy low for 4 cycles after the start pulse -> scheduler stays in
//     WAIT_ACK and issues no second start.

Source files
------------

// File: rtl/sparse_round_scheduler_pkg.sv
// Shared types, sizes and helpers for the sparse round scheduler.
// Optional dummy-round padding is enabled with DUMMY_INSERT_EN.
package sparse_round_scheduler_pkg;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned MEM_SPARSE_SIZE = 50;
  localparam int unsigned POLY_BITS       = 17669;
  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned CNT_W           = 6;
  localparam int unsigned POS_W           = 16;

  localparam logic [POS_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [POS_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_END,
    S_FINISH
  } state_e;

  function automatic logic [POS_W-1:0] pos_hi(input logic [WORD_WIDTH-1:0] w);
    return w[WORD_WIDTH-1:POS_W];
  endfunction

  function automatic logic [POS_W-1:0] pos_lo(input logic [WORD_WIDTH-1:0] w);
    return w[POS_W-1:0];
  endfunction

  function automatic logic pos_valid(input logic [WORD_WIDTH-1:0] w);
    return (pos_hi(w) < POS_W'(POLY_BITS)) && (pos_lo(w) < POS_W'(POLY_BITS));
  endfunction

  // Right-shifting Galois LFSR step.
  function automatic logic [POS_W-1:0] lfsr_step(input logic [POS_W-1:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
  endfunction

  // 16-bit values are below 4*POLY_BITS, so three conditional subtracts always land in range.
  function automatic logic [POS_W-1:0] pos_mod(input logic [POS_W-1:0] x);
    logic [POS_W-1:0] r;
    r = x;
    for (int i = 0; i < 3; i++) begin
      if (r >= POS_W'(POLY_BITS)) r = r - POS_W'(POLY_BITS);
    end
    return r;
  endfunction

endpackage

// File: rtl/sparse_round_scheduler_dummy_pos_gen.sv
// Dummy position-pair generator: LFSR plus modular reduction, 1-cycle latency per request.
// Only built when DUMMY_INSERT_EN is defined.
`ifdef DUMMY_INSERT_EN
module sparse_round_scheduler_dummy_pos_gen
  import sparse_round_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next_i,
  output logic [WORD_WIDTH-1:0] pair_o
);

  logic [POS_W-1:0]      lfsr_q, lfsr_d;
  logic [POS_W-1:0]      lfsr_a, lfsr_b;
  logic [WORD_WIDTH-1:0] pair_q, pair_d;

  // Two successive steps give the high and low positions.
  always_comb begin
    lfsr_a = lfsr_step(lfsr_q);
    lfsr_b = lfsr_step(lfsr_a);
    lfsr_d = lfsr_q;
    pair_d = pair_q;
    if (next_i) begin
      lfsr_d = lfsr_b;
      pair_d = {pos_mod(lfsr_a), pos_mod(lfsr_b)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      pair_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      pair_q <= pair_d;
    end
  end

  assign pair_o = pair_q;

endmodule
`endif

// File: rtl/sparse_round_scheduler.sv
// Walks the sparse-position memory and runs one controller round per valid pair.
// Define DUMMY_INSERT_EN to pad every job to MEM_SPARSE_SIZE rounds with dummy pairs.
module sparse_round_scheduler
  import sparse_round_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      sparse_count,
  output logic [ADDR_W-1:0]     sparse_mem_addr_o,
  input  logic [WORD_WIDTH-1:0] sparse_mem_data_i,
  output logic [WORD_WIDTH-1:0] ctrl_word_o,
  output logic                  ctrl_start_o,
  output logic                  ctrl_dummy_o,
  input  logic                  ctrl_busy_i,
  output logic [CNT_W-1:0]      round_idx_o,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      round_q, round_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      round_idx_q, round_idx_d;
  logic                  busy_q, busy_d;
  logic                  range_err_q, range_err_d;
  logic                  ctrl_start_q, ctrl_start_d;
  logic                  done_q, done_d;

  logic [CNT_W-1:0]      rd_ptr_inc;
  logic [CNT_W-1:0]      round_inc;
  logic [CNT_W-1:0]      count_clamp;

  assign rd_ptr_inc  = rd_ptr_q + CNT_W'(1);
  assign round_inc   = round_q + CNT_W'(1);
  assign count_clamp = (sparse_count > CNT_W'(MEM_SPARSE_SIZE)) ? CNT_W'(MEM_SPARSE_SIZE)
                                                               : sparse_count;

`ifdef DUMMY_INSERT_EN
  logic                  dummy_q, dummy_d;
  logic                  gen_next_c;
  logic [WORD_WIDTH-1:0] gen_pair;

  sparse_round_scheduler_dummy_pos_gen u_dummy_pos_gen (
    .clk    (clk),
    .rst    (rst),
    .next_i (gen_next_c),
    .pair_o (gen_pair)
  );
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    round_d      = round_q;
    addr_d       = addr_q;
    word_d       = word_q;
    round_idx_d  = round_idx_q;
    busy_d       = busy_q;
    range_err_d  = range_err_q;
    ctrl_start_d = 1'b0;
    done_d       = 1'b0;
`ifdef DUMMY_INSERT_EN
    dummy_d      = dummy_q;
    gen_next_c   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d     = count_clamp;
          rd_ptr_d    = '0;
          round_d     = '0;
          addr_d      = '0;
          busy_d      = 1'b1;
          range_err_d = 1'b0;
`ifdef DUMMY_INSERT_EN
          state_d     = S_FETCH;
`else
          state_d     = (count_clamp == '0) ? S_FINISH : S_FETCH;
`endif
        end
      end

      S_FETCH: begin
`ifdef DUMMY_INSERT_EN
        gen_next_c = (rd_ptr_q >= count_q);
`endif
        state_d = S_LATCH;
      end

      // Real entries are range-checked here; bad ones are skipped without consuming a round.
      S_LATCH: begin
        if (rd_ptr_q < count_q) begin
          rd_ptr_d = rd_ptr_inc;
          if (!pos_valid(sparse_mem_data_i)) begin
            range_err_d = 1'b1;
            if (rd_ptr_inc < count_q) begin
              addr_d  = ADDR_W'(rd_ptr_inc);
              state_d = S_FETCH;
            end else begin
`ifdef DUMMY_INSERT_EN
              state_d = (round_q < CNT_W'(MEM_SPARSE_SIZE)) ? S_FETCH : S_FINISH;
`else
              state_d = S_FINISH;
`endif
            end
          end else begin
            word_d       = sparse_mem_data_i;
            round_idx_d  = round_q;
            ctrl_start_d = 1'b1;
            state_d      = S_ISSUE;
`ifdef DUMMY_INSERT_EN
            dummy_d      = 1'b0;
`endif
          end
        end else begin
`ifdef DUMMY_INSERT_EN
          word_d       = gen_pair;
          round_idx_d  = round_q;
          ctrl_start_d = 1'b1;
          dummy_d      = 1'b1;
          state_d      = S_ISSUE;
`else
          state_d      = S_FINISH;
`endif
        end
      end

      S_ISSUE: state_d = S_WAIT_ACK;

      S_WAIT_ACK: begin
        if (ctrl_busy_i) state_d = S_WAIT_END;
      end

      // Falling busy ends the round.
      S_WAIT_END: begin
        if (!ctrl_busy_i) begin
          round_d = round_inc;
`ifdef DUMMY_INSERT_EN
          dummy_d = 1'b0;
`endif
          if (rd_ptr_q < count_q) begin
            addr_d  = ADDR_W'(rd_ptr_q);
            state_d = S_FETCH;
          end else begin
`ifdef DUMMY_INSERT_EN
            state_d = (round_inc < CNT_W'(MEM_SPARSE_SIZE)) ? S_FETCH : S_FINISH;
`else
            state_d = S_FINISH;
`endif
          end
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      round_q      <= '0;
      addr_q       <= '0;
      word_q       <= '0;
      round_idx_q  <= '0;
      busy_q       <= 1'b0;
      range_err_q  <= 1'b0;
      ctrl_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      round_q      <= round_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      round_idx_q  <= round_idx_d;
      busy_q       <= busy_d;
      range_err_q  <= range_err_d;
      ctrl_start_q <= ctrl_start_d;
      done_q       <= done_d;
    end
  end

`ifdef DUMMY_INSERT_EN
  always_ff @(posedge clk) begin
    if (rst) dummy_q <= 1'b0;
    else     dummy_q <= dummy_d;
  end
  assign ctrl_dummy_o = dummy_q;
`else
  assign ctrl_dummy_o = 1'b0;
`endif

  assign sparse_mem_addr_o = addr_q;
  assign ctrl_word_o       = word_q;
  assign ctrl_start_o      = ctrl_start_q;
  assign round_idx_o       = round_idx_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign range_err         = range_err_q;

endmodule
